// File: rtl/rsm_controller.sv
// rsm_controller: instruction register, decoder and step sequencer driving the Simple RISC Machine datapath
module rsm_controller #(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              s,
  input  logic              load,
  input  logic [DATA_W-1:0] in,
  output logic              w,
  output logic [2:0]        readnum,
  output logic [2:0]        writenum,
  output logic              write,
  output logic              vsel,
  output logic              loada,
  output logic              loadb,
  output logic              asel,
  output logic              bsel,
  output logic [1:0]        shift,
  output logic [1:0]        ALUop,
  output logic              loadc,
  output logic              loads,
  output logic [DATA_W-1:0] datapath_in
);
  typedef enum logic [2:0] {WAIT, DECODE, WRITE_IMM, GET_A, GET_B, EXEC, WRITE_REG} state_t;
  state_t state, next;
  logic [DATA_W-1:0] ir;
  logic [2:0] opcode, rn, rd, rm;
  logic [1:0] op, sh;
  logic is_movi, is_movr, is_alu, is_mvn, is_cmp;
  assign opcode = ir[15:13];
  assign op = ir[12:11];
  assign rn = ir[10:8];
  assign rd = ir[7:5];
  assign sh = ir[4:3];
  assign rm = ir[2:0];
  assign is_movi = opcode == 3'b110 && op == 2'b10;
  assign is_movr = opcode == 3'b110 && op == 2'b00;
  assign is_alu = opcode == 3'b101;
  assign is_mvn = is_alu && op == 2'b11;
  assign is_cmp = is_alu && op == 2'b01;
  assign datapath_in = {{(DATA_W-8){ir[7]}}, ir[7:0]};
  assign bsel = 1'b0;
  // IR only accepts a new word while idle, so a running instruction keeps its operands
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= WAIT;
      ir <= '0;
    end else begin
      state <= next;
      if (state == WAIT && load) ir <= in;
    end
  end
  always_comb begin
    next = state;
    w = 1'b0;
    readnum = 3'd0;
    writenum = 3'd0;
    write = 1'b0;
    vsel = 1'b0;
    loada = 1'b0;
    loadb = 1'b0;
    asel = 1'b0;
    shift = 2'b00;
    ALUop = 2'b00;
    loadc = 1'b0;
    loads = 1'b0;
    case (state)
      WAIT: begin
        w = 1'b1;
        next = s ? DECODE : WAIT;
      end
      DECODE: next = is_movi ? WRITE_IMM : (is_movr || is_mvn) ? GET_B : is_alu ? GET_A : WAIT;
      WRITE_IMM: begin
        writenum = rn;
        vsel = 1'b1;
        write = 1'b1;
        next = WAIT;
      end
      GET_A: begin
        readnum = rn;
        loada = 1'b1;
        next = GET_B;
      end
      GET_B: begin
        readnum = rm;
        loadb = 1'b1;
        next = EXEC;
      end
      // register MOV is computed as 0 + shifted Rm
      EXEC: begin
        shift = sh;
        loadc = 1'b1;
        asel = is_movr;
        ALUop = is_movr ? 2'b00 : op;
        loads = is_cmp;
        next = is_cmp ? WAIT : WRITE_REG;
      end
      WRITE_REG: begin
        writenum = rd;
        write = 1'b1;
        next = WAIT;
      end
      default: next = WAIT;
    endcase
  end
endmodule

// File: tb/tb_rsm_controller.sv
// tb_rsm_controller: table vectors, corner sequences and randomized checking against a step-list model
module tb_rsm_controller;
  logic clk = 1'b0, reset_n = 1'b0, s = 1'b0, load = 1'b0;
  logic [15:0] in = 16'h0000;
  logic w, write, vsel, loada, loadb, asel, bsel, loadc, loads;
  logic [2:0] readnum, writenum;
  logic [1:0] shift, ALUop;
  logic [15:0] datapath_in;
  int checks = 0, errors = 0;

  rsm_controller #(.DATA_W(16)) dut (
    .clk(clk), .reset_n(reset_n), .s(s), .load(load), .in(in), .w(w),
    .readnum(readnum), .writenum(writenum), .write(write), .vsel(vsel),
    .loada(loada), .loadb(loadb), .asel(asel), .bsel(bsel), .shift(shift),
    .ALUop(ALUop), .loadc(loadc), .loads(loads), .datapath_in(datapath_in)
  );

  always #5 clk = ~clk;

  logic [18:0] ctl;
  assign ctl = {w, readnum, writenum, write, vsel, loada, loadb, asel, bsel, shift, ALUop, loadc, loads};
  localparam logic [18:0] WAIT_VEC = 19'h40000;

  // small datapath so register results can be checked
  logic [15:0] rf [8];
  logic [15:0] a = 16'h0, b = 16'h0, c = 16'h0, bs, ain, alu;
  logic z = 1'b0;
  initial for (int i = 0; i < 8; i++) rf[i] = 16'h0;
  always_comb begin
    bs = shift == 2'd0 ? b : shift == 2'd1 ? {b[14:0], 1'b0} : shift == 2'd2 ? {1'b0, b[15:1]} : {b[15], b[15:1]};
    ain = asel ? 16'h0 : a;
    alu = ALUop == 2'd0 ? ain + bs : ALUop == 2'd1 ? ain - bs : ALUop == 2'd2 ? ain & bs : ~bs;
  end
  always @(posedge clk) begin
    if (write) rf[writenum] <= vsel ? datapath_in : c;
    if (loada) a <= rf[readnum];
    if (loadb) b <= rf[readnum];
    if (loadc) c <= alu;
    if (loads) z <= alu == 16'h0;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, act, exp);
    end
  endtask

  function automatic logic [15:0] sx(input logic [15:0] i);
    return 16'($signed(i[7:0]));
  endfunction

  function automatic logic [18:0] vec(input int rn, wn, wr, vs, la, lb, as, sh, op, lc, ls);
    return {1'b0, 3'(rn), 3'(wn), 1'(wr), 1'(vs), 1'(la), 1'(lb), 1'(as), 1'b0, 2'(sh), 2'(op), 1'(lc), 1'(ls)};
  endfunction

  // expected control vectors for each non-idle step of an instruction
  logic [18:0] expq[$];
  task automatic plan(input logic [15:0] i);
    logic [2:0] opc;
    logic [1:0] op;
    bit movr, cmp;
    opc = i[15:13];
    op = i[12:11];
    movr = opc == 3'b110 && op == 2'b00;
    cmp = opc == 3'b101 && op == 2'b01;
    expq.delete();
    expq.push_back(19'h0);
    if (opc == 3'b110 && op == 2'b10) expq.push_back(vec(0, i[10:8], 1, 1, 0, 0, 0, 0, 0, 0, 0));
    else if (movr || opc == 3'b101) begin
      if (opc == 3'b101 && op != 2'b11) expq.push_back(vec(i[10:8], 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
      expq.push_back(vec(i[2:0], 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
      expq.push_back(vec(0, 0, 0, 0, 0, 0, movr, i[4:3], movr ? 0 : op, 1, cmp));
      if (!cmp) expq.push_back(vec(0, i[7:5], 1, 0, 0, 0, 0, 0, 0, 0, 0));
    end
  endtask

  task automatic run_instr(input string nm, input logic [15:0] instr, input int lat, input int ri, input logic [15:0] rv, input int zx);
    int n;
    load = 1'b1;
    in = instr;
    s = 1'b1;
    plan(instr);
    tick;
    load = 1'b0;
    s = 1'b0;
    n = 1;
    while (w !== 1'b1 && n < 20) begin
      chk({nm, "_step"}, ctl, n - 1 < expq.size() ? expq[n-1] : WAIT_VEC);
      tick;
      n++;
    end
    chk({nm, "_latency"}, n, lat);
    chk({nm, "_idle"}, ctl, WAIT_VEC);
    chk({nm, "_reg"}, rf[ri], rv);
    chk({nm, "_din"}, datapath_in, sx(instr));
    if (zx >= 0) chk({nm, "_z"}, z, zx);
  endtask

  typedef struct {
    string nm;
    logic [15:0] instr;
    int lat;
    int ri;
    logic [15:0] rv;
    int zx;
  } vec_t;
  vec_t tbl[12];

  initial begin
    logic [15:0] ir_m, ni;
    bit rst;
    tbl[0]  = '{"unsup0", 16'h0000, 2, 0, 16'h0000, -1};
    tbl[1]  = '{"movi_r3", 16'hD342, 3, 3, 16'h0042, -1};
    tbl[2]  = '{"movi_r7", 16'hD7FF, 3, 7, 16'hFFFF, -1};
    tbl[3]  = '{"movi_r5", 16'hD513, 3, 5, 16'h0013, -1};
    tbl[4]  = '{"add", 16'hA543, 6, 2, 16'h0055, -1};
    tbl[5]  = '{"cmp_ne", 16'hAD03, 5, 2, 16'h0055, 0};
    tbl[6]  = '{"mvn", 16'hB880, 5, 4, 16'hFFFF, 0};
    tbl[7]  = '{"movr_lsl", 16'hC02B, 5, 1, 16'h0084, 0};
    tbl[8]  = '{"and", 16'hB7C5, 6, 6, 16'h0013, 0};
    tbl[9]  = '{"cmp_eq", 16'hAB03, 5, 3, 16'h0042, 1};
    tbl[10] = '{"unsup7", 16'hE000, 2, 2, 16'h0055, 1};
    tbl[11] = '{"unsup6", 16'hC8FF, 2, 2, 16'h0055, 1};
    tick;
    tick;
    reset_n = 1'b1;
    chk("reset_ctl", ctl, WAIT_VEC);
    chk("reset_din", datapath_in, 16'h0000);
    for (int i = 0; i < 12; i++) run_instr(tbl[i].nm, tbl[i].instr, tbl[i].lat, tbl[i].ri, tbl[i].rv, tbl[i].zx);
    // abort in GET_B of an ADD that would change R2
    run_instr("movi_r5b", 16'hD520, 3, 5, 16'h0020, -1);
    load = 1'b1; in = 16'hA543; s = 1'b1;
    tick;
    load = 1'b0; s = 1'b0;
    tick;
    tick;
    chk("abort_getb", ctl, vec(3, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
    reset_n = 1'b0;
    tick;
    reset_n = 1'b1;
    chk("abort_idle", ctl, WAIT_VEC);
    chk("abort_ir", datapath_in, 16'h0000);
    tick;
    tick;
    chk("abort_r2", rf[2], 16'h0055);
    // load while busy must not disturb the running ADD
    load = 1'b1; in = 16'hA543; s = 1'b1;
    tick;
    s = 1'b0; in = 16'hD2FF;
    for (int i = 0; i < 4; i++) tick;
    load = 1'b0;
    tick;
    chk("busy_idle", ctl, WAIT_VEC);
    chk("busy_r2", rf[2], 16'h0062);
    chk("busy_din", datapath_in, 16'h0043);
    // s held high re-executes
    load = 1'b1; in = 16'hD611; s = 1'b1;
    tick;
    load = 1'b0;
    tick;
    tick;
    chk("hold_idle", ctl, WAIT_VEC);
    tick;
    chk("hold_rerun", ctl, 19'h0);
    s = 1'b0;
    tick;
    tick;
    chk("hold_r6", rf[6], 16'h0011);
    chk("hold_done", ctl, WAIT_VEC);
    // randomized traffic against the step-list model
    ir_m = 16'hD611;
    expq.delete();
    for (int cyc = 0; cyc < 800; cyc++) begin
      chk("rand_ctl", ctl, expq.size() != 0 ? expq[0] : WAIT_VEC);
      chk("rand_din", datapath_in, sx(ir_m));
      rst = $urandom_range(0, 39) == 0;
      s = $urandom_range(0, 2) == 0;
      load = 1'($urandom_range(0, 1));
      ni = 16'($urandom);
      case ($urandom_range(0, 3))
        1: ni[15:13] = 3'b110;
        2, 3: ni[15:13] = 3'b101;
        default: ;
      endcase
      in = ni;
      reset_n = !rst;
      if (rst) begin
        ir_m = 16'h0;
        expq.delete();
      end else if (expq.size() == 0) begin
        if (load) ir_m = in;
        if (s) plan(ir_m);
      end else void'(expq.pop_front());
      tick;
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
